pipelined_carry_select_adder: RTL and testbench
===============================================

# pipelined_carry_select_adder

Parametrised, pipelined carry-select adder/subtractor with a valid/ready handshake on both sides. The WIDTH-bit operands are split into NSEG = WIDTH/BLOCK segments. Each segment is computed twice, once assuming carry-in 0 and once assuming carry-in 1, and the correct result is selected by the registered carry from the previous stage. One segment resolves per pipeline stage, giving one result per cycle at high clock rates. The block sits in the datapath wherever the fixed 4-bit carry-select adder is too narrow, too slow combinationally, or needs subtract and overflow reporting.

## Interface
- WIDTH, 16, operand and result width; must be a multiple of BLOCK.
- BLOCK, 4, segment width; also sets NSEG = WIDTH/BLOCK, which is the number of stages and the latency.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in when adding; borrow-in when subtracting.
- sub  input  1  0 computes a+b+cin; 1 computes a−b−cin.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- **Effective operands**
  - bx = b XOR {WIDTH{sub}}.
  - c0 = cin XOR sub.
  - Result is the (WIDTH+1)-bit value a + bx + c0: sum is the low WIDTH bits, cout is the top bit.
- **Stage 0**
  - Adds segment 0 (bits BLOCK−1:0) with carry-in c0.
  - Registers the segment-0 sum, the segment carry, the remaining a/bx segments, a[MSB], bx[MSB] and a valid bit.
- **Stage k (1..NSEG−1)**
  - Two BLOCK-wide ripple adders compute segment k with carry 0 and with carry 1.
  - A 2:1 mux selects sum and carry using stage k−1's registered carry.
  - Already-resolved low segments are passed through.
  - Unresolved high segments are delayed in skew registers.
- **Output**
  - The last stage's registers drive sum, cout, ovf and out_valid directly, with no output logic after the flops.
  - ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
- **Handshake**
  - advance = ~out_valid | out_ready.
  - in_ready = advance.
  - An input is accepted when in_valid & in_ready.
  - When advance = 1, every stage loads from the stage before it, and stage 0 loads valid = in_valid.
  - When advance = 0, every stage register holds its value.
- **Bubbles and capacity**
  - Stalls are global, so bubbles are not compressed.
  - Capacity is NSEG results. Results leave in acceptance order; none are dropped or duplicated.
- **Output stability**
  - While out_valid & ~out_ready, sum, cout and ovf hold stable.
- **Degenerate case**
  - NSEG = 1 gives a single registered stage with latency 1.
- **Parameter check**
  - WIDTH % BLOCK != 0 or BLOCK < 1 is illegal and is flagged by a generate-time $error.

## Timing
- **Reset state**
  - While rst_n = 0: every valid bit = 0, out_valid = 0, sum = 0, cout = 0, ovf = 0, and all data/skew registers = 0.
  - in_ready = 1 during and after reset.
- **Reset mid-operation**
  - Asserting rst_n discards all in-flight data immediately (asynchronously).
  - After release, no stale result ever appears.
- **Latency**
  - An input accepted at edge t appears with out_valid = 1 after edge t+NSEG−1, i.e. NSEG cycles from acceptance when there are no stalls.
- **Throughput**
  - One result per cycle while out_ready = 1.
- **Simultaneous events**
  - Input accept and output consume in the same cycle are both legal; occupancy is unchanged.
- **Combinational paths**
  - out_ready → in_ready is combinational, one gate.
  - The critical path is one BLOCK-bit ripple plus one mux level.
  - No other input-to-output combinational path exists.

## Test plan
- **Wrap-around:** defaults, a=0xFFFF, b=0x0001, cin=0, sub=0 → after 4 cycles sum=0x0000, cout=1, ovf=0.
- **Subtract:** a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0 (borrow), ovf=0.
- **Signed overflow:** a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout=0, ovf=1. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1.
- **Backpressure:** in_valid held high with incrementing operands, out_ready=0 → exactly 4 accepted, then in_ready=0 and out_valid=1 with the first result held stable. Then out_ready=1 → results drain in order, one per cycle, and intake resumes.
- **Reset mid-flight:** 3 transactions in flight, rst_n pulsed low → out_valid=0 and sum=0 immediately; after release no output until new input plus 4 cycles.
- **Parameter sweep:** configs (8,8), (16,4), (32,8) with 10k random a/b/cin/sub and random in_valid/out_ready → every result matches the model a ± b ± cin (including cout and ovf); latency is NSEG when unstalled.

Source files
------------

// File: rtl/pipelined_carry_select_adder.sv
// pipelined_carry_select_adder
//
// Pipelined carry-select adder/subtractor. The WIDTH-bit operands are cut
// into NSEG = WIDTH/BLOCK segments. Each pipeline stage resolves one
// segment, so the design produces one result per cycle with a short
// critical path.
//
// Stage 0 adds segment 0 with the effective carry-in. Every later stage k
// computes segment k twice, once for carry-in 0 and once for carry-in 1.
// The registered carry from stage k-1 then selects one of the two results.
// Operand bits that have not been used yet travel down the pipe in skew
// registers, alongside the partial sum that has already been resolved.
//
// Subtraction uses a - b - cin = a + ~b + ~cin. So bx = b ^ {WIDTH{sub}}
// and c0 = cin ^ sub. In subtract mode cout = 1 means "no borrow".
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands this cycle
//   a, b       WIDTH-bit operands
//   cin        carry-in (add) / borrow-in (subtract)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        WIDTH-bit result, modulo 2^WIDTH
//   cout       carry out of the MSB
//   ovf        two's-complement signed overflow
module pipelined_carry_select_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = (BLOCK >= 1) ? (WIDTH / BLOCK) : 1;
    localparam bit BAD_PARAMS = (BLOCK < 1) ? 1'b1 : ((WIDTH % BLOCK) != 0);

    // Reject any geometry that does not split into whole segments.
    generate
        if (BAD_PARAMS) begin : g_param_check
            $error("pipelined_carry_select_adder: WIDTH must be a positive multiple of BLOCK");
        end
    endgenerate

    // Effective operands after folding in the subtract control.
    logic [WIDTH-1:0] bx_in;
    logic             c0_in;

    // Per-stage pipeline state (_q) and the value each stage would load (_d).
    logic [WIDTH-1:0] sum_q   [NSEG];
    logic [WIDTH-1:0] sum_d   [NSEG];
    logic [WIDTH-1:0] a_q     [NSEG];
    logic [WIDTH-1:0] a_d     [NSEG];
    logic [WIDTH-1:0] bx_q    [NSEG];
    logic [WIDTH-1:0] bx_d    [NSEG];
    logic             carry_q [NSEG];
    logic             carry_d [NSEG];
    logic             valid_q [NSEG];
    logic             valid_d [NSEG];

    logic             ovf_q;
    logic             ovf_d;

    // Segment adder results. The top bit of each is the segment carry-out.
    logic [BLOCK:0]   seg0_res;
    logic [BLOCK:0]   seg_c0;
    logic [BLOCK:0]   seg_c1;
    logic [BLOCK:0]   seg_sel;

    logic             advance;

    assign bx_in = b ^ {WIDTH{sub}};
    assign c0_in = cin ^ sub;

    // Stalls are global. The pipe moves as a whole whenever the output slot
    // is empty or is being drained, so the ready path is a single gate.
    assign advance  = ~out_valid | out_ready;
    assign in_ready = advance;

    // Next-state logic for every stage.
    // Stage 0 adds segment 0 with the effective carry-in. Stage k selects
    // between two precomputed segment sums using stage k-1's registered
    // carry. Resolved low segments and the still-unused operand bits are
    // copied forward unchanged. The overflow flag is computed here, from
    // the last stage's incoming values, so that ovf comes straight from a
    // flop.
    always_comb begin
        seg0_res = '0;
        seg_c0   = '0;
        seg_c1   = '0;
        seg_sel  = '0;
        for (int k = 0; k < NSEG; k++) begin
            sum_d[k]   = '0;
            a_d[k]     = '0;
            bx_d[k]    = '0;
            carry_d[k] = 1'b0;
            valid_d[k] = 1'b0;
        end

        seg0_res = {1'b0, a[BLOCK-1:0]} + {1'b0, bx_in[BLOCK-1:0]}
                 + {{BLOCK{1'b0}}, c0_in};
        sum_d[0][BLOCK-1:0] = seg0_res[BLOCK-1:0];
        carry_d[0]          = seg0_res[BLOCK];
        a_d[0]              = a;
        bx_d[0]             = bx_in;
        valid_d[0]          = in_valid;

        for (int k = 1; k < NSEG; k++) begin
            seg_c0  = {1'b0, a_q[k-1][k*BLOCK +: BLOCK]}
                    + {1'b0, bx_q[k-1][k*BLOCK +: BLOCK]};
            seg_c1  = {1'b0, a_q[k-1][k*BLOCK +: BLOCK]}
                    + {1'b0, bx_q[k-1][k*BLOCK +: BLOCK]}
                    + {{BLOCK{1'b0}}, 1'b1};
            seg_sel = carry_q[k-1] ? seg_c1 : seg_c0;

            sum_d[k]                   = sum_q[k-1];
            sum_d[k][k*BLOCK +: BLOCK] = seg_sel[BLOCK-1:0];
            carry_d[k]                 = seg_sel[BLOCK];
            a_d[k]                     = a_q[k-1];
            bx_d[k]                    = bx_q[k-1];
            valid_d[k]                 = valid_q[k-1];
        end

        ovf_d = (a_d[NSEG-1][WIDTH-1] == bx_d[NSEG-1][WIDTH-1])
             && (sum_d[NSEG-1][WIDTH-1] != a_d[NSEG-1][WIDTH-1]);
    end

    // Pipeline registers.
    // Reset clears every stage, so nothing in flight can reappear after
    // reset is released. When the pipe is stalled, every stage keeps its
    // value. This holds the output stable and keeps bubbles where they are.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSEG; k++) begin
                sum_q[k]   <= '0;
                a_q[k]     <= '0;
                bx_q[k]    <= '0;
                carry_q[k] <= 1'b0;
                valid_q[k] <= 1'b0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSEG; k++) begin
                sum_q[k]   <= sum_d[k];
                a_q[k]     <= a_d[k];
                bx_q[k]    <= bx_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = valid_q[NSEG-1];
    assign sum       = sum_q[NSEG-1];
    assign cout      = carry_q[NSEG-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// tb_pipelined_carry_select_adder
//
// Self-checking bench for pipelined_carry_select_adder (WIDTH=16, BLOCK=4).
// When an input is accepted, a reference computes its result from plain
// signed and unsigned arithmetic and queues it. A negedge scoreboard then
// checks every consumed result against that queue. The same process also
// checks that the output holds steady under backpressure, that out_valid
// never appears with nothing in flight, and that outputs read as zero in
// reset. Directed cases pin literal values, latency, capacity and reset
// behaviour. A random phase then exercises the handshake.
module tb_pipelined_carry_select_adder;

    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NSEG  = WIDTH / BLOCK;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int checks = 0;
    int errors = 0;

    logic [WIDTH+1:0] expQ[$];
    logic             holdPrev = 1'b0;
    logic [WIDTH+1:0] heldData = '0;

    pipelined_carry_select_adder #(
        .WIDTH(WIDTH),
        .BLOCK(BLOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something hangs.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference result, packed as {cout, ovf, sum}.
    function automatic logic [WIDTH+1:0] modelCalc(input logic [WIDTH-1:0] x,
                                                   input logic [WIDTH-1:0] y,
                                                   input logic ci,
                                                   input logic s);
        logic [WIDTH:0] u;
        logic           co;
        logic           ov;
        longint         sx;
        longint         sy;
        longint         sres;
        longint         smax;
        longint         smin;
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        if (!s) begin
            u    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
            co   = u[WIDTH];
            sres = sx + sy + longint'(ci);
        end else begin
            u    = {1'b0, x} - {1'b0, y} - {{WIDTH{1'b0}}, ci};
            co   = ~u[WIDTH];
            sres = sx - sy - longint'(ci);
        end
        ov = (sres > smax) || (sres < smin);
        return {co, ov, u[WIDTH-1:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [WIDTH-1:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 16'hFFFF;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'h0000;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    // Scoreboard. It samples on the falling edge, midway between drive and capture.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            holdPrev = 1'b0;
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_sum", sum, 0);
            checkOutput("reset_cout_ovf", {cout, ovf}, 0);
            checkOutput("reset_in_ready", in_ready, 1);
        end else begin
            if (holdPrev) begin
                checkOutput("hold_valid", out_valid, 1);
                checkOutput("hold_data", {cout, ovf, sum}, heldData);
            end
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", out_valid, 0);
                end else if (out_ready) begin
                    checkOutput("result", {cout, ovf, sum}, expQ.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(modelCalc(a, b, cin, sub));
            end
            checkOutput("occupancy_over_nseg", expQ.size() > NSEG, 0);
            holdPrev = out_valid && !out_ready;
            heldData = {cout, ovf, sum};
        end
    end

    // Present operands until the DUT accepts them. On return the time is
    // just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic ci, input logic s, input logic keepValid);
        logic done;
        done     = 1'b0;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = s;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!keepValid) in_valid = 1'b0;
        if (!done) checkOutput("accept_timeout", 0, 1);
    endtask

    task automatic runDirected(input string name, input logic [WIDTH-1:0] x,
                               input logic [WIDTH-1:0] y, input logic ci, input logic s,
                               input logic [WIDTH-1:0] esum, input logic ecout,
                               input logic eovf);
        int   lat;
        logic got;
        out_ready = 1'b1;
        applyStimulus(x, y, ci, s, 1'b0);
        lat = 1;
        got = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        checkOutput({name, "_seen"}, got, 1);
        checkOutput({name, "_latency"}, lat, NSEG);
        checkOutput({name, "_sum"}, sum, esum);
        checkOutput({name, "_cout"}, cout, ecout);
        checkOutput({name, "_ovf"}, ovf, eovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int accepted;
        logic accThis;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_in_ready", in_ready, 1);
        checkOutput("post_reset_out_valid", out_valid, 0);

        $display("[TB] directed arithmetic cases");
        runDirected("wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        runDirected("sub_borrow",16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        runDirected("ovf_add",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        runDirected("ovf_sub",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        runDirected("add_cin",   16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        runDirected("sub_bin",   16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0);
        runDirected("seg_carry", 16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        in_valid  = 1'b1;
        accepted  = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            a   = 16'h0100 + WIDTH'(accepted);
            b   = WIDTH'(accepted);
            cin = 1'b0;
            sub = 1'b0;
            @(negedge clk);
            accThis = in_ready;
            @(posedge clk);
            #1;
            if (accThis) accepted++;
        end
        @(negedge clk);
        checkOutput("bp_accepted", accepted, NSEG);
        checkOutput("bp_in_ready", in_ready, 0);
        checkOutput("bp_out_valid", out_valid, 1);
        checkOutput("bp_first_sum", sum, 16'h0100);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            @(negedge clk);
            checkOutput("bp_drain_valid", out_valid, 1);
            checkOutput("bp_drain_sum", sum, 16'h0100 + WIDTH'(2 * i));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("bp_drained_empty", out_valid, 0);
        @(posedge clk);
        #1;
        runDirected("bp_resume", 16'h00AA, 16'h0055, 1'b0, 1'b0, 16'h00FF, 1'b0, 1'b0);

        $display("[TB] reset mid-flight");
        out_ready = 1'b1;
        for (int i = 0; i < NSEG; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 1'($urandom), 1'($urandom), 1'b1);
        end
        in_valid = 1'b0;
        #2;
        checkOutput("rst_pre_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_valid", out_valid, 0);
        checkOutput("rst_async_sum", sum, 0);
        checkOutput("rst_async_in_ready", in_ready, 1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("rst_no_stale", out_valid, 0);
        end
        @(posedge clk);
        #1;
        runDirected("rst_after", 16'h2222, 16'h1111, 1'b0, 1'b1, 16'h1111, 1'b1, 1'b0);

        $display("[TB] random handshake traffic");
        for (int cyc = 0; cyc < 4000; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 70);
            a         = pickOperand();
            b         = pickOperand();
            cin       = 1'($urandom);
            sub       = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (NSEG + 2) @(posedge clk);
        @(negedge clk);
        checkOutput("final_queue_empty", expQ.size(), 0);
        checkOutput("final_out_valid", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
